fetch_unit: RTL and testbench
=============================

# fetch_unit

Front-end fetch stage of the tartaruga core. It owns the architectural fetch PC, drives it to the instruction cache, and captures each hit instruction with its PC into a small in-order fetch queue. Decode drains the queue over a valid/ready handshake. Execute can redirect the PC on a taken branch or jump, which flushes the queue in the same cycle.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.
- FETCH_QUEUE_DEPTH, 4, queue entries; power of two, 2..16.
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- pc_o  out  32 (bus32_t)  fetch PC presented to the instruction cache.
- icache_instr_i  in  32 (instruction_t)  instruction word for pc_o; combinational from the cache.
- icache_valid_i  in  1  cache hit for pc_o in the current cycle.
- redirect_valid_i  in  1  taken branch or jump from execute.
- redirect_pc_i  in  32 (bus32_t)  redirect target.
- decode_valid_o  out  1  queue head is valid.
- decode_ready_i  in  1  decode accepts the head this cycle.
- decode_instr_o  out  32 (instruction_t)  queue head instruction.
- decode_pc_o  out  32 (bus32_t)  queue head PC.

## Operation
- State:
  - pc_q, 32 bits.
  - Circular queue of {pc, instr} entries, FETCH_QUEUE_DEPTH deep.
  - Read and write pointers, $clog2(FETCH_QUEUE_DEPTH) bits each, wrapping modulo depth.
  - count, $clog2(FETCH_QUEUE_DEPTH)+1 bits, range 0..FETCH_QUEUE_DEPTH.
- pc_o = pc_q at all times.
- full = (count == FETCH_QUEUE_DEPTH); empty = (count == 0).
- push = icache_valid_i && !full && !redirect_valid_i.
  - Writes {pc_q, icache_instr_i} at the write pointer.
  - Advances the write pointer.
  - pc_q <= pc_q + 32'd4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- No push:
  - On a cache miss (icache_valid_i = 0), pc_q holds. The cache issues its own line refill, and the same PC is re-presented every cycle until it hits.
  - When the queue is full, pc_q holds even if the cache hits. The hit is discarded and re-fetched later.
- decode_valid_o = !empty && !redirect_valid_i.
- pop = decode_valid_o && decode_ready_i. Advances the read pointer.
- count update on a normal cycle: count <= count + push - pop. Push and pop may occur in the same cycle; count is unchanged.
- A full queue does not accept a push in a cycle that pops. Full is evaluated on the registered count, so there is no ready-to-push combinational path.
- Redirect (redirect_valid_i = 1) has priority over everything:
  - pc_q <= {redirect_pc_i[31:2], 2'b00}; low bits are forced to zero.
  - count <= 0; both pointers <= 0.
  - No push and no pop that cycle.
- Head data:
  - When non-empty, decode_instr_o and decode_pc_o show the entry at the read pointer.
  - When empty, decode_instr_o = NOP_INSTR_HEX and decode_pc_o = 32'h0.
- Ordering: decode receives instructions in strictly increasing PC order (+4) between redirects, with no duplicates and no gaps.

## Timing
- Reset (asynchronous, rstn_i low):
  - pc_o = RESET_PC.
  - count = 0 and pointers = 0.
  - decode_valid_o = 0, decode_instr_o = NOP_INSTR_HEX, decode_pc_o = 0.
  - Reset asserted mid-stream discards all queue contents immediately, without waiting for a clock edge.
- Fetch-to-decode latency: an instruction that hits in cycle N is visible as the head (if the queue was empty) in cycle N+1.
- Throughput: 1 instruction per cycle while the cache hits and decode keeps up. The steady state is push+pop every cycle at count 1.
- Redirect asserted in cycle N:
  - pc_o = target in cycle N+1.
  - The first post-redirect hit can be the head in cycle N+2.
- Redirect held for several cycles: the block reloads pc_q from redirect_pc_i every such cycle, keeps the queue empty, and asserts no decode_valid_o.
- Decode handshake rules:
  - decode_valid_o does not depend on decode_ready_i.
  - While decode_valid_o = 1 and no redirect occurs, the head is stable until popped.

## Test plan
- Reset then hit stream: RESET_PC = 0, icache_valid_i = 1 every cycle, decode_ready_i = 1 -> decode_pc_o sequence 0x0, 0x4, 0x8, ... one per cycle starting the cycle after the first hit, each paired with the matching icache_instr_i.
- Backpressure fill: decode_ready_i = 0 with continuous hits from PC 0x100 -> 4 pushes, count = 4, pc_o holds at 0x110. Then ready = 1 -> 0x100..0x10C drain in order and fetch resumes at 0x110.
- Miss stall: icache_valid_i low for 5 cycles at PC 0x40 -> pc_o stays 0x40 and no push occurs. Then the hit is enqueued with PC 0x40 and pc_o becomes 0x44.
- Redirect flush: queue holds 3 entries and redirect_pc_i = 0x2003 -> decode_valid_o = 0 in the redirect cycle, count = 0 next cycle, pc_o = 0x2000, and the next head is PC 0x2000.
- Redirect with simultaneous hit and ready: the hit at the current PC is not enqueued and the head is not popped -> the queue is empty afterward and the only later entries start at the target.
- Wrap and async reset: redirect to 0xFFFF_FFFC with hits -> the next entries have PCs 0xFFFF_FFFC, 0x0000_0000. Dropping rstn_i mid-stream -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, captures instruction-cache hits into an
// in-order circular queue, and hands the queue head to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          FETCH_QUEUE_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR_HEX     = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [31:0] pc_o,
  input  logic [31:0] icache_instr_i,
  input  logic        icache_valid_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        decode_valid_o,
  input  logic        decode_ready_i,
  output logic [31:0] decode_instr_o,
  output logic [31:0] decode_pc_o
);

  localparam int PTR_W = $clog2(FETCH_QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FETCH_QUEUE_DEPTH);

  logic [31:0]      r_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_q_pc    [FETCH_QUEUE_DEPTH];
  logic [31:0]      r_q_instr [FETCH_QUEUE_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full comes from the registered count, so a pop never frees a slot for
  // a push in the same cycle.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = icache_valid_i && !w_full && !redirect_valid_i;
  assign w_pop   = decode_valid_o && decode_ready_i;

  assign pc_o           = r_pc;
  assign decode_valid_o = !w_empty && !redirect_valid_i;
  assign decode_instr_o = w_empty ? NOP_INSTR_HEX : r_q_instr[r_rd_ptr];
  assign decode_pc_o    = w_empty ? 32'h0 : r_q_pc[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid_i) begin
      r_pc     <= {redirect_pc_i[31:2], 2'b00};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_pc;
      r_q_instr[r_wr_ptr] <= icache_instr_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference PC/queue model fills a
// scoreboard as hits are driven and each DUT pop is compared against it.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] pc_o;
  logic [31:0] icache_instr_i;
  logic        icache_valid_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        decode_valid_o;
  logic        decode_ready_i;
  logic [31:0] decode_instr_o;
  logic [31:0] decode_pc_o;

  fetch_unit #(
    .RESET_PC          (32'h0000_0000),
    .FETCH_QUEUE_DEPTH (DEPTH),
    .NOP_INSTR_HEX     (NOP)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .pc_o             (pc_o),
    .icache_instr_i   (icache_instr_i),
    .icache_valid_i   (icache_valid_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .decode_valid_o   (decode_valid_o),
    .decode_ready_i   (decode_ready_i),
    .decode_instr_o   (decode_instr_o),
    .decode_pc_o      (decode_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] m_pc = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] o_pc, o_hpc, o_hinstr, e_pc;
  logic        o_valid, e_valid, e_pop;
  entry_t      e_ent;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One cycle: apply inputs at negedge, sample outputs, then advance the model
  // to what the following rising edge should produce.
  task automatic drive(input logic v, input logic r, input logic rd, input logic [31:0] rpc);
    logic full;
    @(negedge clk_i);
    icache_valid_i   = v;
    decode_ready_i   = r;
    redirect_valid_i = rd;
    redirect_pc_i    = rpc;
    icache_instr_i   = instr_of(m_pc);
    #1;
    o_pc     = pc_o;
    o_valid  = decode_valid_o;
    o_hpc    = decode_pc_o;
    o_hinstr = decode_instr_o;
    e_pc     = m_pc;
    e_valid  = (sb.size() > 0) && !rd;
    e_pop    = e_valid && r;
    if (rd) begin
      sb.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      full = (sb.size() == DEPTH);
      if (e_pop) e_ent = sb.pop_front();
      if (v && !full) begin
        sb.push_back({m_pc, instr_of(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    icache_valid_i = 1'b0; decode_ready_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'h0; icache_instr_i = 32'h0;
    #3;
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
    n_checks++; if (decode_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", decode_valid_o); end
    n_checks++; if (decode_instr_o !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", decode_instr_o, NOP); end
    n_checks++; if (decode_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_dpc got=%h exp=0", decode_pc_o); end
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_stream();
    int pops = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      n_checks++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL stream_pc cyc=%0d got=%h exp=%h", i, o_pc, e_pc); end
      n_checks++; if (o_valid !== e_valid) begin n_fail++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, o_valid, e_valid); end
      if (e_pop) begin
        n_checks++;
        if (o_hpc !== e_ent.pc || o_hinstr !== e_ent.instr) begin
          n_fail++; $display("FAIL stream_head cyc=%0d got=%h/%h exp=%h/%h", i, o_hpc, o_hinstr, e_ent.pc, e_ent.instr);
        end
      end
      if (o_valid === 1'b1) pops++;
    end
    n_checks++; if (pops !== 9) begin n_fail++; $display("FAIL stream_throughput got=%0d exp=9", pops); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) begin
      if (i == 0) drive(1'b0, 1'b0, 1'b1, 32'h100);
      else        drive(1'b1, i >= 7, 1'b0, 32'h0);
      n_checks++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL bp_pc cyc=%0d got=%h exp=%h", i, o_pc, e_pc); end
      n_checks++; if (o_valid !== e_valid) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, o_valid, e_valid); end
      if (e_pop) begin
        n_checks++;
        if (o_hpc !== e_ent.pc || o_hinstr !== e_ent.instr) begin
          n_fail++; $display("FAIL bp_head cyc=%0d got=%h/%h exp=%h/%h", i, o_hpc, o_hinstr, e_ent.pc, e_ent.instr);
        end
      end
      if (i == 6) begin
        n_checks++; if (o_pc !== 32'h110) begin n_fail++; $display("FAIL bp_hold_pc got=%h exp=%h", o_pc, 32'h110); end
        n_checks++; if (o_hpc !== 32'h100) begin n_fail++; $display("FAIL bp_hold_head got=%h exp=%h", o_hpc, 32'h100); end
      end
    end
  endtask

  task automatic test_miss();
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      drive(1'b0, 1'b0, 1'b1, 32'h40);
      else if (i <= 5) drive(1'b0, 1'b0, 1'b0, 32'h0);
      else if (i == 6) drive(1'b1, 1'b0, 1'b0, 32'h0);
      else             drive(1'b0, i >= 8, 1'b0, 32'h0);
      n_checks++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL miss_pc cyc=%0d got=%h exp=%h", i, o_pc, e_pc); end
      n_checks++; if (o_valid !== e_valid) begin n_fail++; $display("FAIL miss_valid cyc=%0d got=%b exp=%b", i, o_valid, e_valid); end
      if (i >= 1 && i <= 6) begin
        n_checks++; if (o_pc !== 32'h40) begin n_fail++; $display("FAIL miss_stall_pc cyc=%0d got=%h exp=%h", i, o_pc, 32'h40); end
      end
      if (i == 7) begin
        n_checks++; if (o_pc !== 32'h44) begin n_fail++; $display("FAIL miss_next_pc got=%h exp=%h", o_pc, 32'h44); end
        n_checks++; if (o_hpc !== 32'h40) begin n_fail++; $display("FAIL miss_head got=%h exp=%h", o_hpc, 32'h40); end
      end
      if (e_pop) begin
        n_checks++;
        if (o_hpc !== e_ent.pc || o_hinstr !== e_ent.instr) begin
          n_fail++; $display("FAIL miss_pop cyc=%0d got=%h/%h exp=%h/%h", i, o_hpc, o_hinstr, e_ent.pc, e_ent.instr);
        end
      end
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 14; i++) begin
      if (i == 0)                drive(1'b0, 1'b0, 1'b1, 32'h300);
      else if (i <= 3)           drive(1'b1, 1'b0, 1'b0, 32'h0);
      else if (i == 4)           drive(1'b1, 1'b1, 1'b1, 32'h2003);
      else if (i == 5 || i == 7) drive(1'b0, 1'b1, 1'b0, 32'h0);
      else if (i == 6)           drive(1'b1, 1'b1, 1'b0, 32'h0);
      else if (i <= 10)          drive(1'b1, 1'b1, 1'b1, 32'h5009 + 32'(i));
      else                       drive(1'b1, 1'b1, 1'b0, 32'h0);
      n_checks++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL redir_pc cyc=%0d got=%h exp=%h", i, o_pc, e_pc); end
      n_checks++; if (o_valid !== e_valid) begin n_fail++; $display("FAIL redir_valid cyc=%0d got=%b exp=%b", i, o_valid, e_valid); end
      if (i == 4 && o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush_valid got=%b exp=0", o_valid); end
      if (i == 5) begin
        n_checks++; if (o_pc !== 32'h2000) begin n_fail++; $display("FAIL redir_target got=%h exp=%h", o_pc, 32'h2000); end
      end
      if (i == 7) begin
        n_checks++; if (o_hpc !== 32'h2000) begin n_fail++; $display("FAIL redir_head got=%h exp=%h", o_hpc, 32'h2000); end
      end
      if (i == 12) begin
        n_checks++; if (o_hpc !== 32'h5010) begin n_fail++; $display("FAIL redir_held_head got=%h exp=%h", o_hpc, 32'h5010); end
      end
      if (e_pop) begin
        n_checks++;
        if (o_hpc !== e_ent.pc || o_hinstr !== e_ent.instr) begin
          n_fail++; $display("FAIL redir_pop cyc=%0d got=%h/%h exp=%h/%h", i, o_hpc, o_hinstr, e_ent.pc, e_ent.instr);
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      else if (i <= 2) drive(1'b1, 1'b0, 1'b0, 32'h0);
      else             drive(1'b0, i >= 4, 1'b0, 32'h0);
      n_checks++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL wrap_pc cyc=%0d got=%h exp=%h", i, o_pc, e_pc); end
      n_checks++; if (o_valid !== e_valid) begin n_fail++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", i, o_valid, e_valid); end
      if (i == 3) begin
        n_checks++; if (o_pc !== 32'h4) begin n_fail++; $display("FAIL wrap_next_pc got=%h exp=%h", o_pc, 32'h4); end
        n_checks++; if (o_hpc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_head0 got=%h exp=%h", o_hpc, 32'hFFFF_FFFC); end
      end
      if (i == 5) begin
        n_checks++; if (o_hpc !== 32'h0) begin n_fail++; $display("FAIL wrap_head1 got=%h exp=%h", o_hpc, 32'h0); end
      end
      if (e_pop) begin
        n_checks++;
        if (o_hpc !== e_ent.pc || o_hinstr !== e_ent.instr) begin
          n_fail++; $display("FAIL wrap_pop cyc=%0d got=%h/%h exp=%h/%h", i, o_hpc, o_hinstr, e_ent.pc, e_ent.instr);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h800);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    icache_valid_i = 1'b0; decode_ready_i = 1'b0; redirect_valid_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL arst_pc got=%h exp=0", pc_o); end
    n_checks++; if (decode_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", decode_valid_o); end
    n_checks++; if (decode_instr_o !== NOP) begin n_fail++; $display("FAIL arst_instr got=%h exp=%h", decode_instr_o, NOP); end
    n_checks++; if (decode_pc_o !== 32'h0) begin n_fail++; $display("FAIL arst_dpc got=%h exp=0", decode_pc_o); end
    sb.delete();
    m_pc = 32'h0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      n_checks++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL arst_restart_pc cyc=%0d got=%h exp=%h", i, o_pc, e_pc); end
      n_checks++; if (o_valid !== e_valid) begin n_fail++; $display("FAIL arst_restart_valid cyc=%0d got=%b exp=%b", i, o_valid, e_valid); end
      if (e_pop) begin
        n_checks++;
        if (o_hpc !== e_ent.pc || o_hinstr !== e_ent.instr) begin
          n_fail++; $display("FAIL arst_restart_head cyc=%0d got=%h/%h exp=%h/%h", i, o_hpc, o_hinstr, e_ent.pc, e_ent.instr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_miss();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
